// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: datapath width,
// sequencer state encoding and ALU function codes.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SETTLE  = ST_SETTLE,
    PUBLISH = ST_PUBLISH
  } alu_state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_INC = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_CLR = 3'd7
  } alu_func_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU core: result and carry from operands and function code.
module alu_comb
  import alu_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  alu_func_e    func,
  output logic [N-1:0] result,
  output logic         carry
);

  logic [N:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (func)
      ALU_ADD: begin
        sum    = {1'b0, b} + {1'b0, c};
        result = sum[N-1:0];
        carry  = sum[N];
      end
      ALU_INC: begin
        sum    = {1'b0, b} + (N+1)'(1);
        result = sum[N-1:0];
        carry  = sum[N];
      end
      ALU_AND: result = b & c;
      ALU_OR:  result = b | c;
      ALU_XOR: result = b ^ c;
      ALU_NOT: result = ~b;
      // Circular rotate: the MSB wraps into bit 0, nothing reaches carry.
      ALU_SHL: result = {b[N-2:0], b[N-1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU stage feeding register A: captures operands on start, waits a settle
// delay, then publishes a held result with sign/carry/zero flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N             = DATA_W,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] b_in,
  input  logic [N-1:0] c_in,
  input  logic [2:0]   func,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] alu_result,
  output logic         cond_sign,
  output logic         cond_carry,
  output logic         cond_zero,
  output logic         led_alu,
  output alu_state_e   state_dbg
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  // Handshake: start is a level request, accepted only on a clock edge seen
  // in IDLE; a start in SETTLE or PUBLISH is dropped, never queued. done is
  // a single-cycle pulse coinciding with the new alu_result and flags.
  alu_state_e   state;
  logic [3:0]   counter;
  logic [N-1:0] op_b;
  logic [N-1:0] op_c;
  alu_func_e    op_func;
  logic [N-1:0] comb_result;
  logic         comb_carry;

  alu_comb #(.N(N)) u_comb (
    .b      (op_b),
    .c      (op_c),
    .func   (op_func),
    .result (comb_result),
    .carry  (comb_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      op_b       <= '0;
      op_c       <= '0;
      op_func    <= ALU_ADD;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_result <= '0;
      cond_sign  <= 1'b0;
      cond_carry <= 1'b0;
      cond_zero  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_b    <= b_in;
            op_c    <= c_in;
            op_func <= alu_func_e'(func);
            counter <= SETTLE_INIT;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          // Result registers load on the edge entering PUBLISH so they are
          // valid during the whole done cycle.
          if (counter == 4'd0) begin
            state      <= PUBLISH;
            busy       <= 1'b0;
            done       <= 1'b1;
            alu_result <= comb_result;
            cond_carry <= comb_carry;
            cond_sign  <= comb_result[N-1];
            cond_zero  <= (comb_result == '0);
          end else begin
            counter <= counter - 4'd1;
          end
        end
        PUBLISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign led_alu   = busy;
  assign state_dbg = state;

endmodule
